// File: rtl/matriz_led_varredura_pkg.sv
// Shared defaults and width helper for the multiplexed LED matrix scanner.
package matriz_led_varredura_pkg;

    localparam int N_COL_PADRAO = 2;
    localparam int N_LIN_PADRAO = 7;
    localparam int DIV_PADRAO   = 1000;
    localparam int BLANK_PADRAO = 4;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/divisor_varredura.sv
// Column-slot prescaler: counts 0..DIV-1 while enabled, ticks on the last count.
module divisor_varredura
    import matriz_led_varredura_pkg::*;
#(
    parameter int DIV = DIV_PADRAO
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [clog2(DIV)-1:0] cnt,
    output logic                  tick
);

    localparam int CW = clog2(DIV);
    localparam logic [CW-1:0] CNT_ULT = CW'(DIV - 1);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == CNT_ULT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == CNT_ULT);

endmodule

// File: rtl/matriz_led_varredura.sv
// Column-scanned LED matrix driver with double-buffered frame data.
// Outputs decode registered state only; swaps happen at frame boundaries.
module matriz_led_varredura
    import matriz_led_varredura_pkg::*;
#(
    parameter int N_COL = N_COL_PADRAO,
    parameter int N_LIN = N_LIN_PADRAO,
    parameter int DIV   = DIV_PADRAO,
    parameter int BLANK = BLANK_PADRAO
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [N_COL*N_LIN-1:0]  din,
    input  logic                    load,
    output logic [N_LIN-1:0]        lin,
    output logic [N_COL-1:0]        col,
    output logic [clog2(N_COL)-1:0] col_idx,
    output logic                    frame_done
);

    localparam int CW = clog2(DIV);
    localparam int IW = clog2(N_COL);
    localparam logic [IW-1:0] COL_ULT   = IW'(N_COL - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

    logic                   run;
    logic                   en_div;
    logic                   tick;
    logic                   fim_quadro;
    logic                   troca;
    logic                   ativo;
    logic                   pending;
    logic [CW-1:0]          cnt;
    logic [N_COL*N_LIN-1:0] display;
    logic [N_COL*N_LIN-1:0] shadow;
    logic [N_LIN-1:0]       coluna [N_COL];

    // run delays en by one edge so the first enabled cycle sits at cnt=0
    // and no output ever depends combinationally on en.
    assign en_div = en && run;

    divisor_varredura #(
        .DIV (DIV)
    ) u_divisor (
        .clk  (clk),
        .rst  (rst),
        .en   (en_div),
        .cnt  (cnt),
        .tick (tick)
    );

    assign fim_quadro = tick && (col_idx == COL_ULT);
    assign troca      = (!en || fim_quadro) && (pending || load);

    always_ff @(posedge clk) begin
        if (rst) begin
            run        <= 1'b0;
            col_idx    <= '0;
            frame_done <= 1'b0;
            display    <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
        end else begin
            run        <= en;
            frame_done <= fim_quadro;

            if (!en_div) begin
                col_idx <= '0;
            end else if (tick) begin
                col_idx <= (col_idx == COL_ULT) ? '0 : col_idx + 1'b1;
            end

            if (load) begin
                shadow <= din;
            end

            // A load in the swap cycle bypasses shadow so it is not lost.
            if (troca) begin
                display <= load ? din : shadow;
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < N_COL; c++) begin : g_coluna
        assign coluna[c] = display[c*N_LIN +: N_LIN];
    end

    assign ativo = run && ((BLANK == 0) || (cnt >= CNT_BLANK));

    always_comb begin
        col = '0;
        lin = '1;
        if (ativo) begin
            col[col_idx] = 1'b1;
            lin          = ~coluna[col_idx];
        end
    end

endmodule

// File: tb/tb_matriz_led_varredura.sv
// Randomized and directed checks of the LED matrix scanner against a position-based model.
module tb_matriz_led_varredura;

    localparam int NC = 2;
    localparam int NL = 4;
    localparam int DV = 4;
    localparam int BK = 1;
    localparam int FR = NC * DV;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, load;
    logic [NC*NL-1:0] din;
    logic [NL-1:0] lin;
    logic [NC-1:0] col;
    logic [0:0]    col_idx;
    logic          frame_done;

    logic          rst2, en2, load2;
    logic [13:0]   din2;
    logic [6:0]    lin2;
    logic [1:0]    col2;
    logic [0:0]    col_idx2;
    logic          frame_done2;

    matriz_led_varredura #(
        .N_COL (NC),
        .N_LIN (NL),
        .DIV   (DV),
        .BLANK (BK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .load       (load),
        .lin        (lin),
        .col        (col),
        .col_idx    (col_idx),
        .frame_done (frame_done)
    );

    matriz_led_varredura dut_padrao (
        .clk        (clk),
        .rst        (rst2),
        .en         (en2),
        .din        (din2),
        .load       (load2),
        .lin        (lin2),
        .col        (col2),
        .col_idx    (col_idx2),
        .frame_done (frame_done2)
    );

    int n_aval   = 0;
    int n_falhas = 0;

    // Model: pos = edges since the scan (re)started, -1 while dark.
    int               pos      = -1;
    logic [NC*NL-1:0] m_disp   = '0;
    logic [NC*NL-1:0] m_shadow = '0;
    bit               m_pend   = 1'b0;
    bit               m_fd     = 1'b0;

    task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_aval++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    task automatic model_edge();
        bit eof;
        if (rst) begin
            pos      = -1;
            m_disp   = '0;
            m_shadow = '0;
            m_pend   = 1'b0;
            m_fd     = 1'b0;
        end else begin
            eof  = en && (pos >= 0) && (pos % FR == FR - 1);
            m_fd = eof;
            if ((!en || eof) && (m_pend || load)) begin
                m_disp = load ? din : m_shadow;
                m_pend = 1'b0;
            end else if (load) begin
                m_pend = 1'b1;
            end
            if (load) m_shadow = din;
            if (!en) pos = -1;
            else     pos = (pos < 0) ? 0 : (pos + 1) % FR;
        end
    endtask

    task automatic check_outputs();
        int c;
        bit drv;
        logic [NC-1:0] ec;
        logic [NL-1:0] el;
        c   = (pos < 0) ? 0 : (pos / DV) % NC;
        drv = (pos >= 0) && ((pos % DV) >= BK);
        ec  = drv ? NC'(1 << c) : '0;
        el  = '1;
        if (drv) for (int r = 0; r < NL; r++) el[r] = ~m_disp[c*NL + r];
        confere("col", col, ec);
        confere("lin", lin, el);
        confere("col_idx", col_idx, c);
        confere("frame_done", frame_done, m_fd);
        confere("col_onehot", $countones(col) <= 1, 1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic step_ate(input logic [NC-1:0] alvo, input string tag);
        bit achou;
        achou = 1'b0;
        for (int i = 0; i < 4*FR && !achou; i++) begin
            step();
            if (col == alvo) achou = 1'b1;
        end
        confere(tag, achou, 1);
    endtask

    initial begin
        int  n_fd;
        bit  achou;
        int  acesos [14];

        rst = 1'b1; en = 1'b0; load = 1'b0; din = '0;
        rst2 = 1'b1; en2 = 1'b0; load2 = 1'b0; din2 = '0;

        // Reset state
        step(); step();
        confere("rst_col", col, 0);
        confere("rst_lin", lin, 4'hF);
        confere("rst_fd", frame_done, 0);

        // Plain scan, nothing loaded
        rst = 1'b0; en = 1'b1;
        step();
        n_fd = 0;
        for (int i = 0; i < 3*FR; i++) begin
            step();
            if (frame_done) n_fd++;
        end
        confere("scan_fd_count", n_fd, 3);

        // Load mid-frame: stays dark until the frame ends
        step();
        load = 1'b1; din = 8'hA5;
        step();
        load = 1'b0;
        achou = 1'b0;
        for (int i = 0; i < 2*FR && !achou; i++) begin
            step();
            if (frame_done) achou = 1'b1;
            else if (col == 2'b01) confere("load_col0_dark", lin, 4'hF);
        end
        confere("load_wait_fd", achou, 1);
        step_ate(2'b01, "load_find_col0");
        confere("load_col0_lin", lin, 4'b1010);
        step_ate(2'b10, "load_find_col1");
        confere("load_col1_lin", lin, 4'b0101);

        // Two loads in one frame: the last one wins
        load = 1'b1; din = 8'hFF;
        step();
        din = 8'h0F;
        step();
        load = 1'b0;
        step_ate(2'b01, "dbl_find_col0");
        confere("dbl_col0_lin", lin, 4'b0000);
        step_ate(2'b10, "dbl_find_col1");
        confere("dbl_col1_lin", lin, 4'b1111);

        // Load landing exactly on the frame-end edge
        achou = (pos == FR - 1);
        for (int i = 0; i < 2*FR && !achou; i++) begin
            step();
            if (pos == FR - 1) achou = 1'b1;
        end
        confere("edge_wait_end", achou, 1);
        load = 1'b1; din = 8'h3C;
        step();
        load = 1'b0;
        step_ate(2'b01, "edge_find_col0");
        confere("edge_col0_lin", lin, 4'b0011);
        step_ate(2'b10, "edge_find_col1");
        confere("edge_col1_lin", lin, 4'b1100);

        // Enable dropped mid-slot
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            confere("dis_col", col, 0);
            confere("dis_lin", lin, 4'hF);
            confere("dis_fd", frame_done, 0);
        end
        en = 1'b1;
        step();
        confere("reen_blank_col", col, 0);
        confere("reen_idx", col_idx, 0);
        step();
        confere("reen_col0", col, 2'b01);

        // Reset during column 1 drive clears the display
        step_ate(2'b10, "rst_find_col1");
        rst = 1'b1;
        step();
        confere("midrst_col", col, 0);
        confere("midrst_idx", col_idx, 0);
        confere("midrst_lin", lin, 4'hF);
        rst = 1'b0;
        for (int i = 0; i < 2*FR + 2; i++) begin
            step();
            if (col != 0) confere("midrst_cleared", lin, 4'hF);
        end

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom % 97) == 0;
            en   = ($urandom % 16) != 0;
            load = ($urandom % 6) == 0;
            din  = NC*NL'($urandom);
            step();
        end
        rst = 1'b0; en = 1'b0; load = 1'b0;

        // Default geometry: lit-cycle count per LED over one frame
        @(posedge clk); #1;
        rst2  = 1'b0;
        din2  = 14'($urandom);
        load2 = 1'b1;
        @(posedge clk); #1;
        load2 = 1'b0;
        en2   = 1'b1;
        achou = 1'b0;
        for (int i = 0; i < 5000 && !achou; i++) begin
            @(posedge clk); #1;
            confere("dflt_onehot", $countones(col2) <= 1, 1);
            if (frame_done2) achou = 1'b1;
        end
        confere("dflt_wait_fd", achou, 1);
        for (int i = 0; i < 14; i++) acesos[i] = 0;
        for (int k = 0; k < 2000; k++) begin
            confere("dflt_onehot", $countones(col2) <= 1, 1);
            for (int c = 0; c < 2; c++)
                for (int r = 0; r < 7; r++)
                    if (col2[c] && !lin2[r]) acesos[c*7 + r]++;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 14; i++)
            confere("dflt_lit_count", acesos[i], din2[i] ? 996 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falhas);
        $finish;
    end

endmodule

// File: doc/matriz_led_varredura.md
MATRIZ_LED_VARREDURA -- requirements
Module: matriz_led_varredura

Interface
REQ-001 Parameter N_COL, default 2, number of matrix columns (>=2).
REQ-002 Parameter N_LIN, default 7, number of matrix rows (>=1).
REQ-003 Parameter DIV, default 1000, clock cycles per column slot (>=2).
REQ-004 Parameter BLANK, default 4, blanked cycles at slot start (0 <= BLANK < DIV).
REQ-005 clk  input  1  single system clock, all state on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  scan enable; 0 = display dark.
REQ-008 din  input  N_COL*N_LIN  frame data; bit c*N_LIN+r = LED (column c, row r), 1 = lit.
REQ-009 load  input  1  one-cycle strobe capturing din into the shadow buffer.
REQ-010 lin  output  N_LIN  row drive, active-low (0 = row conducts).
REQ-011 col  output  N_COL  column drive, active-high, one-hot or all-zero.
REQ-012 col_idx  output  clog2(N_COL)  index of the column currently in its slot.
REQ-013 frame_done  output  1  one-cycle pulse at end of the last column slot.

Function
REQ-014 Prescaler cnt counts 0..DIV-1 while en=1; wraps to 0 after DIV-1.
REQ-015 On cnt=DIV-1, col_idx advances by 1; after N_COL-1 it wraps to 0.
REQ-016 Blank phase (cnt < BLANK) or en=0: col all 0, lin all 1.
REQ-017 Drive phase (cnt >= BLANK, en=1): col = one-hot(col_idx); lin[r] = ~display[col_idx*N_LIN+r].
REQ-018 col, lin and col_idx are combinational decodes of registered state only, with no input-to-output path.
REQ-019 frame_done registers to 1 for exactly the one cycle after the cycle where cnt=DIV-1 and col_idx=N_COL-1.
REQ-020 load=1 writes din into shadow and sets pending; a later load before the swap overwrites shadow.
REQ-021 Swap at frame end (cnt=DIV-1, col_idx=N_COL-1, en=1) when pending or load: display <= (load ? din : shadow), pending <= 0.
REQ-022 Display never changes mid-frame, so no torn frames.
REQ-023 en=0: cnt and col_idx held at 0, frame_done 0, and a pending or concurrent load swaps into display on the next edge.
REQ-024 en 0->1: scan restarts at column 0, cnt 0, beginning with the blank phase.
REQ-025 BLANK=0: no blank phase; the column drives from cnt=0.
REQ-026 Never more than one col bit high in any cycle, including wrap and enable edges.

Reset
REQ-027 rst=1 at a clock edge: cnt=0, col_idx=0, display=0, shadow=0, pending=0, frame_done=0.
REQ-028 Hence during and after reset: col all 0 (blank) or column 0 with lin all 1, so no LED is lit.
REQ-029 rst has priority over en and load; a load in the reset cycle is discarded.
REQ-030 Reset mid-frame abandons the frame and drops pending data with no frame_done.

Structure
REQ-031 Shared package holds parameter defaults and the counter-width function (clog2).
REQ-032 Prescaler is the sub-module divisor_varredura (parameter DIV; ports clk, rst, en, cnt, tick).
REQ-033 The column one-hot decode and the row mux stay inside matriz_led_varredura.

Verification
Bench parameters: N_COL=2, N_LIN=4, DIV=4, BLANK=1 unless stated.
REQ-034 Reset, then en=1, no load -> col pattern per 4 cycles is 00,01,01,01 then 00,10,10,10; lin=1111 throughout; frame_done pulses every 8 cycles.
REQ-035 Load din=8'b1010_0101 mid-frame -> column 0 still dark until frame end; next frame column 0 drive has lin=1010 and column 1 drive has lin=0101.
REQ-036 Two loads in one frame (0xFF then 0x0F) -> only 0x0F is displayed, so column 1 is dark; load coinciding with frame end -> that din is displayed in the next frame.
REQ-037 en=0 mid-slot for 5 cycles, then en=1 -> col=00 and lin=1111 while en=0; scan resumes at column 0 with a blank cycle; no frame_done while en=0.
REQ-038 rst asserted during the drive phase of column 1 -> next cycle col=00, col_idx=0, lin=1111, and display is cleared.
REQ-039 Defaults (N_COL=2, N_LIN=7, DIV=1000, BLANK=4) with a random frame -> assert one-hot-or-zero col every cycle; the lit-cycle count per LED per frame equals 996.
